// File: rtl/fu_broadcast_arbiter_if.sv
// Bus bundle between the functional units / CDB consumer and the broadcast
// arbiter. The master side is the outside world (units plus bus consumer),
// the slave side is the arbiter itself.
interface fu_broadcast_arbiter_if #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 4
);
    localparam int ID_W  = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_FU-1:0]            fu_done;
    logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
    logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
    logic [NUM_FU-1:0]            fu_queued;
    logic                         cdb_valid;
    logic                         cdb_ready;
    logic [DATA_WIDTH-1:0]        cdb_data;
    logic [TAG_WIDTH-1:0]         cdb_tag;
    logic [ID_W-1:0]              cdb_fu_id;
    logic [CNT_W-1:0]             count;
    logic                         full;

    modport master (
        output fu_done, fu_result, fu_tag, cdb_ready,
        input  fu_queued, cdb_valid, cdb_data, cdb_tag, cdb_fu_id, count, full
    );

    modport slave (
        input  fu_done, fu_result, fu_tag, cdb_ready,
        output fu_queued, cdb_valid, cdb_data, cdb_tag, cdb_fu_id, count, full
    );
endinterface

// File: rtl/fu_broadcast_arbiter.sv
// Shared common-data-bus arbiter: latches per-unit done pulses as pending
// requests, grants one unit per cycle round-robin, queues the winner's
// {id, tag, result} in a small FIFO and presents the FIFO head on the CDB.
// Optional statistics counters are enabled with the macro FU_ARB_STATS_EN.
module fu_broadcast_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 4
) (
    input  logic clk,
    input  logic rst,
    fu_broadcast_arbiter_if.slave bus
`ifdef FU_ARB_STATS_EN
    ,
    output logic [31:0] stat_grants,
    output logic [31:0] stat_stall_cycles
`endif
);
    localparam int ID_W    = $clog2(NUM_FU);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ID_W + TAG_WIDTH + DATA_WIDTH;

    // Per-unit views of the flattened result/tag buses
    logic [DATA_WIDTH-1:0] result_arr [NUM_FU];
    logic [TAG_WIDTH-1:0]  tag_arr    [NUM_FU];

    logic [NUM_FU-1:0] pending_reg, pending_next;
    logic [ID_W-1:0]   rr_reg, rr_next;
    logic [NUM_FU-1:0] grant_onehot;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               full_int;
    logic               head_valid;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unpack
            assign result_arr[gi] = bus.fu_result[gi*DATA_WIDTH +: DATA_WIDTH];
            assign tag_arr[gi]    = bus.fu_tag[gi*TAG_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle; the grant simply waits one cycle.
    assign full_int   = (count_reg == CNT_W'(DEPTH));
    assign head_valid = (count_reg != '0);

    // Round-robin winner search starting just above the last winner;
    // reset suppresses the grant immediately.
    always_comb begin
        int idx;
        grant_valid  = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        idx          = 0;
        if (!rst && (pending_reg != '0) && !full_int) begin
            for (int k = 1; k <= NUM_FU; k++) begin
                idx = (int'(rr_reg) + k) % NUM_FU;
                if (!grant_valid && pending_reg[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
        end
        if (grant_valid) begin
            grant_onehot[grant_id] = 1'b1;
        end
    end

    assign push = grant_valid;
    assign pop  = head_valid && bus.cdb_ready;

    // Next-state for pending set/clear (a new done wins over a grant clear),
    // rotation pointer and FIFO occupancy.
    always_comb begin
        pending_next = (pending_reg & ~grant_onehot) | bus.fu_done;
        rr_next      = grant_valid ? grant_id : rr_reg;
        count_next   = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Control state: pending requests, rotation pointer, FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
            rr_reg      <= ID_W'(NUM_FU - 1);
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            rr_reg      <= rr_next;
            count_reg   <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // FIFO storage; entries need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {grant_id, tag_arr[grant_id], result_arr[grant_id]};
        end
    end

    // Head is read combinationally so a granted entry is visible the next cycle.
    assign head_entry = head_valid ? mem[rd_ptr_reg] : '0;

    assign bus.fu_queued = grant_onehot;
    assign bus.cdb_valid = head_valid;
    assign bus.cdb_data  = head_entry[DATA_WIDTH-1:0];
    assign bus.cdb_tag   = head_entry[DATA_WIDTH +: TAG_WIDTH];
    assign bus.cdb_fu_id = head_entry[DATA_WIDTH+TAG_WIDTH +: ID_W];
    assign bus.count     = count_reg;
    assign bus.full      = full_int;

`ifdef FU_ARB_STATS_EN
    logic [31:0] stat_grants_reg;
    logic [31:0] stat_stall_reg;

    // Grant and stall counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_reg <= '0;
            stat_stall_reg  <= '0;
        end else begin
            if (grant_valid) begin
                stat_grants_reg <= stat_grants_reg + 32'd1;
            end
            if ((pending_reg != '0) && full_int) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_grants       = stat_grants_reg;
    assign stat_stall_cycles = stat_stall_reg;
`endif
endmodule

// File: tb/tb_fu_broadcast_arbiter.sv
// Directed bench for fu_broadcast_arbiter (8 units, 4-entry FIFO).
// Expected CDB entries are queued in expected grant order when a unit's
// done is driven, and compared whenever the DUT pops its head.
module tb_fu_broadcast_arbiter;
    localparam int NUM_FU = 8;
    localparam int DW     = 32;
    localparam int TW     = 7;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [2:0]    id;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    fu_broadcast_arbiter_if #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

`ifdef FU_ARB_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_stall_cycles;
`endif

    fu_broadcast_arbiter #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FU_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic unit_done(input int id, input logic [DW-1:0] d, input logic [TW-1:0] t);
        exp_t e;
        bus.fu_result[id*DW +: DW] = d;
        bus.fu_tag[id*TW +: TW]    = t;
        bus.fu_done[id]            = 1'b1;
        e.id   = 3'(id);
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    // Check any pop happening on the coming edge, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (bus.cdb_valid && bus.cdb_ready) begin
            chk("sb_nonempty_at_pop", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("pop id=%0d tag=0x%0h data=0x%08h", bus.cdb_fu_id, bus.cdb_tag, bus.cdb_data);
                chk("head_data", 64'(bus.cdb_data), 64'(e.data));
                chk("head_tag", 64'(bus.cdb_tag), 64'(e.tag));
                chk("head_id", 64'(bus.cdb_fu_id), 64'(e.id));
            end
        end
        @(posedge clk);
        #1;
        bus.fu_done = '0;
    endtask

    task automatic drain();
        bus.cdb_ready = 1'b1;
        #1;
        for (int i = 0; i < 20 && bus.cdb_valid; i++) tick();
        chk("drain_valid", 64'(bus.cdb_valid), 64'd0);
        chk("drain_count", 64'(bus.count), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.fu_done   = '0;
        bus.fu_result = '0;
        bus.fu_tag    = '0;
        bus.cdb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_valid", 64'(bus.cdb_valid), 64'd0);
        chk("reset_queued", 64'(bus.fu_queued), 64'd0);
        chk("reset_full", 64'(bus.full), 64'd0);
        chk("reset_data", 64'(bus.cdb_data), 64'd0);
        chk("reset_tag", 64'(bus.cdb_tag), 64'd0);

        // Single request: done in cycle 0, queued in 1, on CDB in 2, gone in 3
        unit_done(2, 32'h0000_00F0, 7'd5);
        #1;
        chk("single_q_c0", 64'(bus.fu_queued), 64'h00);
        tick();
        chk("single_q_c1", 64'(bus.fu_queued), 64'h04);
        chk("single_valid_c1", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk("single_valid_c2", 64'(bus.cdb_valid), 64'd1);
        chk("single_data_c2", 64'(bus.cdb_data), 64'hF0);
        chk("single_tag_c2", 64'(bus.cdb_tag), 64'd5);
        chk("single_id_c2", 64'(bus.cdb_fu_id), 64'd2);
        tick();
        chk("single_valid_c3", 64'(bus.cdb_valid), 64'd0);

        // Round-robin from reset: four simultaneous dones granted 0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) unit_done(i, 32'h100 + 32'(i), 7'(10 + i));
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 64'(bus.fu_queued), 64'(1) << k);
            tick();
        end
        drain();

        // Rotation: after granting unit 1, unit 3 beats unit 0
        unit_done(1, 32'hAAAA_0001, 7'h21);
        tick();
        chk("rot_grant1", 64'(bus.fu_queued), 64'h02);
        unit_done(3, 32'hAAAA_0003, 7'h23);
        unit_done(0, 32'hAAAA_0000, 7'h20);
        tick();
        chk("rot_grant3", 64'(bus.fu_queued), 64'h08);
        tick();
        chk("rot_grant0", 64'(bus.fu_queued), 64'h01);
        tick();
        drain();

        // Full stall: five requests, consumer stalled; rr last = 0 so 1..4 then 0
        bus.cdb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) unit_done(i, 32'hB000_0000 + 32'(i), 7'(40 + i));
        unit_done(0, 32'hB000_0000, 7'd40);
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk("stall_grant", 64'(bus.fu_queued), 64'(1) << k);
            tick();
        end
        chk("stall_full", 64'(bus.full), 64'd1);
        chk("stall_count", 64'(bus.count), 64'd4);
        chk("stall_q_none", 64'(bus.fu_queued), 64'h00);
        tick();
        chk("stall_q_hold", 64'(bus.fu_queued), 64'h00);
        bus.cdb_ready = 1'b1;
        #1;
        chk("stall_q_pop_cycle", 64'(bus.fu_queued), 64'h00);
        tick();
        bus.cdb_ready = 1'b0;
        #1;
        chk("stall_count_after_pop", 64'(bus.count), 64'd3);
        chk("stall_grant5", 64'(bus.fu_queued), 64'h01);
        tick();
        chk("stall_count_refill", 64'(bus.count), 64'd4);
        drain();

        // Simultaneous push and pop at count 2
        bus.cdb_ready = 1'b0;
        unit_done(5, 32'hC000_0005, 7'd55);
        unit_done(6, 32'hC000_0006, 7'd56);
        tick();
        chk("pp_grant5", 64'(bus.fu_queued), 64'h20);
        tick();
        chk("pp_grant6", 64'(bus.fu_queued), 64'h40);
        unit_done(7, 32'hC000_0007, 7'd57);
        tick();
        chk("pp_count_before", 64'(bus.count), 64'd2);
        chk("pp_grant7", 64'(bus.fu_queued), 64'h80);
        bus.cdb_ready = 1'b1;
        tick();
        chk("pp_count_after", 64'(bus.count), 64'd2);
        drain();

        // Reset mid-operation with three queued entries and units 1,3 pending
        bus.cdb_ready = 1'b0;
        unit_done(0, 32'hD000_0000, 7'd60);
        unit_done(2, 32'hD000_0002, 7'd62);
        unit_done(4, 32'hD000_0004, 7'd64);
        tick();
        chk("mr_grant0", 64'(bus.fu_queued), 64'h01);
        tick();
        chk("mr_grant2", 64'(bus.fu_queued), 64'h04);
        tick();
        chk("mr_grant4", 64'(bus.fu_queued), 64'h10);
        bus.fu_done[1] = 1'b1;
        bus.fu_done[3] = 1'b1;
        tick();
        chk("mr_count3", 64'(bus.count), 64'd3);
        rst = 1'b1;
        #1;
        chk("mr_q_drop", 64'(bus.fu_queued), 64'h00);
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mr_count0", 64'(bus.count), 64'd0);
        chk("mr_valid0", 64'(bus.cdb_valid), 64'd0);
        chk("mr_q0", 64'(bus.fu_queued), 64'h00);
        unit_done(1, 32'hE000_0001, 7'd71);
        unit_done(3, 32'hE000_0003, 7'd73);
        bus.cdb_ready = 1'b1;
        tick();
        chk("mr_first_grant", 64'(bus.fu_queued), 64'h02);
        tick();
        chk("mr_second_grant", 64'(bus.fu_queued), 64'h08);
        tick();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
